// File: rtl/frame_drain_ctrl.sv
`default_nettype none
// ============================================================================
// frame_drain_ctrl : paced whole-frame FIFO reader with full/empty trigger handling
// Revision 1.0 : initial release
// ============================================================================
module frame_drain_ctrl #(
    parameter int FRAME_SIZE   = 1280,
    parameter int START_FRAMES = 3,
    parameter int RD_INTERVAL  = 2,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable_i,
    input  logic              trigger_FIFO_full_i,
    input  logic              trigger_FIFO_empty_i,
    input  logic [20:0]       fifo_rd_data_count_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_dout_i,
    output logic              fifo_rd_en_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_sof_o,
    output logic              out_eof_o,
    output logic              catchup_o,
    output logic              underflow_o,
    output logic [15:0]       frames_read_o
);

    localparam int              WC_W          = (FRAME_SIZE > 1) ? $clog2(FRAME_SIZE) : 1;
    localparam logic [WC_W-1:0] C_LAST_WORD   = WC_W'(FRAME_SIZE - 1);
    localparam logic [3:0]      C_PACE_MAX    = 4'(RD_INTERVAL - 1);
    localparam logic [20:0]     C_START_LEVEL = 21'(FRAME_SIZE * START_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_READ     = 2'd1,
        ST_BOUNDARY = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WC_W-1:0]   word_q, word_d;
    logic [3:0]        pace_q, pace_d;
    logic [15:0]       frames_q, frames_d;
    logic              underflow_q, underflow_d;
    logic              valid_q, sof_q, eof_q;
    logic              due;
    logic              rd_en;
    logic              catchup;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        pace_d      = pace_q;
        frames_d    = frames_q;
        underflow_d = underflow_q;
        due         = 1'b0;
        rd_en       = 1'b0;
        catchup     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && ((fifo_rd_data_count_i >= C_START_LEVEL) || trigger_FIFO_full_i)) begin
                    state_d = ST_READ;
                    word_d  = '0;
                    pace_d  = '0;
                end
            end
            ST_READ: begin
                // Full trigger overrides pacing; an empty FIFO always stalls the read.
                due     = trigger_FIFO_full_i || (pace_q == C_PACE_MAX);
                rd_en   = due && !fifo_empty_i;
                catchup = trigger_FIFO_full_i;
                if (due && fifo_empty_i) begin
                    underflow_d = 1'b1;
                end
                if (rd_en) begin
                    pace_d = '0;
                    if (word_q == C_LAST_WORD) begin
                        state_d = ST_BOUNDARY;
                        word_d  = '0;
                    end else begin
                        word_d = word_q + 1'b1;
                    end
                end else if (pace_q != C_PACE_MAX) begin
                    pace_d = pace_q + 4'd1;
                end
            end
            ST_BOUNDARY: begin
                frames_d = frames_q + 16'd1;
                word_d   = '0;
                pace_d   = '0;
                // The empty trigger only parks the reader between frames.
                if (!enable_i || trigger_FIFO_empty_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            word_q      <= '0;
            pace_q      <= '0;
            frames_q    <= '0;
            underflow_q <= 1'b0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            pace_q      <= pace_d;
            frames_q    <= frames_d;
            underflow_q <= underflow_d;
            valid_q     <= rd_en;
            sof_q       <= rd_en && (word_q == '0);
            eof_q       <= rd_en && (word_q == C_LAST_WORD);
        end
    end

    assign fifo_rd_en_o  = rd_en;
    assign catchup_o     = catchup;
    assign out_valid_o   = valid_q;
    assign out_sof_o     = sof_q;
    assign out_eof_o     = eof_q;
    assign out_data_o    = fifo_dout_i;
    assign underflow_o   = underflow_q;
    assign frames_read_o = frames_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_drain_ctrl.sv
`default_nettype none
// ============================================================================
// tb_frame_drain_ctrl : directed + randomized bench with a frame-level reference model
// Revision 1.0 : initial release
// ============================================================================
module tb_frame_drain_ctrl;

    localparam int FS = 8;
    localparam int SF = 2;
    localparam int RI = 2;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable_i;
    logic          trigger_FIFO_full_i;
    logic          trigger_FIFO_empty_i;
    logic [20:0]   fifo_rd_data_count_i;
    logic          fifo_empty_i;
    logic [DW-1:0] fifo_dout_i;
    logic          fifo_rd_en_o;
    logic          out_valid_o;
    logic [DW-1:0] out_data_o;
    logic          out_sof_o;
    logic          out_eof_o;
    logic          catchup_o;
    logic          underflow_o;
    logic [15:0]   frames_read_o;

    always #5 clk = ~clk;

    frame_drain_ctrl #(
        .FRAME_SIZE  (FS),
        .START_FRAMES(SF),
        .RD_INTERVAL (RI),
        .DATA_W      (DW)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .enable_i            (enable_i),
        .trigger_FIFO_full_i (trigger_FIFO_full_i),
        .trigger_FIFO_empty_i(trigger_FIFO_empty_i),
        .fifo_rd_data_count_i(fifo_rd_data_count_i),
        .fifo_empty_i        (fifo_empty_i),
        .fifo_dout_i         (fifo_dout_i),
        .fifo_rd_en_o        (fifo_rd_en_o),
        .out_valid_o         (out_valid_o),
        .out_data_o          (out_data_o),
        .out_sof_o           (out_sof_o),
        .out_eof_o           (out_eof_o),
        .catchup_o           (catchup_o),
        .underflow_o         (underflow_o),
        .frames_read_o       (frames_read_o)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: frame progress expressed as "words delivered so far"
    // and "cycles waited since the last read or frame start".
    bit          m_known    = 1'b0;
    bit          m_reading  = 1'b0;
    bit          m_boundary = 1'b0;
    int          m_word     = 0;
    int          m_since    = 0;
    bit          m_valid    = 1'b0;
    bit          m_sof      = 1'b0;
    bit          m_eof      = 1'b0;
    bit          m_under    = 1'b0;
    logic [15:0] m_frames   = 16'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit due;
        bit e_rd;
        bit e_cat;
        fifo_dout_i = $urandom;
        @(negedge clk);
        due   = m_reading && (trigger_FIFO_full_i || (m_since >= RI - 1));
        e_rd  = due && !fifo_empty_i;
        e_cat = m_reading && trigger_FIFO_full_i;
        if (m_known) begin
            chk("rd_en",     {31'b0, fifo_rd_en_o}, {31'b0, e_rd});
            chk("catchup",   {31'b0, catchup_o},    {31'b0, e_cat});
            chk("valid",     {31'b0, out_valid_o},  {31'b0, m_valid});
            chk("sof",       {31'b0, out_sof_o},    {31'b0, m_sof});
            chk("eof",       {31'b0, out_eof_o},    {31'b0, m_eof});
            chk("underflow", {31'b0, underflow_o},  {31'b0, m_under});
            chk("frames",    {16'b0, frames_read_o}, {16'b0, m_frames});
            chk("data",      out_data_o,            fifo_dout_i);
        end
        @(posedge clk);
        if (reset) begin
            m_known    = 1'b1;
            m_reading  = 1'b0;
            m_boundary = 1'b0;
            m_word     = 0;
            m_since    = 0;
            m_valid    = 1'b0;
            m_sof      = 1'b0;
            m_eof      = 1'b0;
            m_under    = 1'b0;
            m_frames   = 16'h0;
        end else begin
            m_valid = e_rd;
            m_sof   = e_rd && (m_word == 0);
            m_eof   = e_rd && (m_word == FS - 1);
            if (m_reading) begin
                if (due && fifo_empty_i) m_under = 1'b1;
                if (e_rd) begin
                    m_since = 0;
                    if (m_word == FS - 1) begin
                        m_reading  = 1'b0;
                        m_boundary = 1'b1;
                        m_word     = 0;
                    end else begin
                        m_word++;
                    end
                end else begin
                    m_since++;
                end
            end else if (m_boundary) begin
                m_frames   = m_frames + 16'd1;
                m_boundary = 1'b0;
                if (enable_i && !trigger_FIFO_empty_i) begin
                    m_reading = 1'b1;
                    m_word    = 0;
                    m_since   = 0;
                end
            end else if (enable_i && ((int'(fifo_rd_data_count_i) >= FS * SF) || trigger_FIFO_full_i)) begin
                m_reading = 1'b1;
                m_word    = 0;
                m_since   = 0;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_word(input int w);
        int n;
        n = 0;
        while (!(m_reading && m_word == w) && n < 300) begin
            tick();
            n++;
        end
        chk("wait_word_timeout", (n < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        reset                = 1'b1;
        enable_i             = 1'b1;
        trigger_FIFO_full_i  = 1'b0;
        trigger_FIFO_empty_i = 1'b0;
        fifo_rd_data_count_i = 21'd100;
        fifo_empty_i         = 1'b0;
        fifo_dout_i          = '0;

        // Reset held with data available, then release and read a frame.
        run(3);
        reset = 1'b0;
        tick();
        chk("no_rd_cycle1", {31'b0, fifo_rd_en_o}, 32'd0);
        run(30);

        // Start threshold: one word short stays idle, exact level starts.
        enable_i = 1'b0;
        run(25);
        fifo_rd_data_count_i = 21'd15;
        enable_i             = 1'b1;
        run(20);
        fifo_rd_data_count_i = 21'd16;
        run(24);

        // Catch-up for a whole frame, then back to paced reads.
        wait_word(0);
        trigger_FIFO_full_i = 1'b1;
        run(12);
        trigger_FIFO_full_i = 1'b0;
        run(20);

        // Empty trigger mid-frame: frame completes, then park until refill.
        wait_word(4);
        trigger_FIFO_empty_i = 1'b1;
        fifo_rd_data_count_i = 21'd10;
        run(20);
        trigger_FIFO_empty_i = 1'b0;
        run(10);
        fifo_rd_data_count_i = 21'd16;
        run(25);

        // Underflow: FIFO empty for five cycles mid-frame.
        wait_word(3);
        fifo_empty_i = 1'b1;
        run(5);
        fifo_empty_i = 1'b0;
        run(25);

        // Randomized mix of triggers, stalls, counts, enables and rare resets.
        for (int i = 0; i < 400; i++) begin
            trigger_FIFO_full_i  = ($urandom_range(0, 9) == 0);
            trigger_FIFO_empty_i = ($urandom_range(0, 9) == 0);
            fifo_empty_i         = ($urandom_range(0, 7) == 0);
            fifo_rd_data_count_i = 21'($urandom_range(0, 30));
            enable_i             = ($urandom_range(0, 19) != 0);
            reset                = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset                = 1'b0;
        trigger_FIFO_full_i  = 1'b0;
        trigger_FIFO_empty_i = 1'b0;
        fifo_empty_i         = 1'b0;
        fifo_rd_data_count_i = 21'd100;

        // Frame counter wrap from 0xFFFF.
        enable_i = 1'b0;
        run(25);
        force dut.frames_q = 16'hFFFF;
        m_frames = 16'hFFFF;
        tick();
        release dut.frames_q;
        tick();
        enable_i = 1'b1;
        run(30);
        chk("frames_wrap", {16'b0, frames_read_o}, 32'd0);

        // Reset mid-frame abandons it; next frame restarts at word 0.
        wait_word(5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_valid", {31'b0, out_valid_o}, 32'd0);
        chk("abort_frames", {16'b0, frames_read_o}, 32'd0);
        run(25);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
